clk_gate_ctrl: RTL and testbench
================================

CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

Interface
REQ-001 SHALL have parameter IDLE_CYCLES, default 16: consecutive idle cycles required before gating; legal range 1..2^CNT_W-1.
REQ-002 SHALL have parameter WAKE_CYCLES, default 2: cycles with the clock re-enabled before ready_o asserts; legal range 1..2^CNT_W-1.
REQ-003 SHALL have parameter CNT_W, default 8: width of the shared idle/wake counter.
REQ-004 SHALL have port clk_i, input, 1 bit: free-running clock, the ungated source of the gate cell.
REQ-005 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port idle_i, input, 1 bit: gated domain reports no pending work.
REQ-007 SHALL have port wake_i, input, 1 bit: wake request, already synchronous to clk_i.
REQ-008 SHALL have port force_on_i, input, 1 bit: inhibits gating (debug/test); holds the FSM out of GATED.
REQ-009 SHALL have port test_en_i, input, 1 bit: forwarded to the gate cell test enable.
REQ-010 SHALL have port clk_o, output, 1 bit: gated clock.
REQ-011 SHALL have port clk_en_o, output, 1 bit: registered enable driven into the gate cell.
REQ-012 SHALL have port ready_o, output, 1 bit: domain clocked and safe to issue work.
REQ-013 SHALL have port gated_o, output, 1 bit: FSM is in GATED.

Function
REQ-014 SHALL implement FSM states RUN, IDLE_WAIT, GATED and WAKE; all outputs SHALL be registered and decoded from the next state.
REQ-015 RUN: clk_en_o=1, ready_o=1; idle_i=1 & wake_i=0 & force_on_i=0 SHALL move to IDLE_WAIT with the counter cleared.
REQ-016 IDLE_WAIT: clk_en_o=1, ready_o=1; the counter SHALL increment each cycle idle_i=1.
REQ-017 IDLE_WAIT: idle_i=0, wake_i=1 or force_on_i=1 SHALL return to RUN; abort SHALL take priority over the gate decision in the same cycle.
REQ-018 IDLE_WAIT: counter==IDLE_CYCLES-1 with idle_i=1 SHALL move to GATED.
REQ-019 GATED: clk_en_o=0, ready_o=0, gated_o=1; wake_i=1, force_on_i=1 or idle_i=0 SHALL move to WAKE with the counter cleared.
REQ-020 WAKE: clk_en_o=1, ready_o=0; the counter SHALL increment each cycle and move to RUN when counter==WAKE_CYCLES-1; idle_i SHALL be ignored in WAKE.
REQ-021 Latency: with idle_i held high from edge 0, clk_en_o SHALL fall after edge IDLE_CYCLES+1; ready_o SHALL rise WAKE_CYCLES+1 edges after the wake trigger is sampled.
REQ-022 The counter SHALL never wrap; the compare SHALL terminate counting before 2^CNT_W-1.

Reset
REQ-023 While rst_i=1: state=RUN, counter=0, clk_en_o=1, ready_o=1, gated_o=0.
REQ-024 rst_i asserted in any state, including GATED, SHALL re-enable the clock immediately (asynchronous) and SHALL NOT emit a runt pulse on clk_o.

Configuration
REQ-025 Macro CLK_GATE_CTRL_STATS_EN defined: SHALL add input stats_clr_i (1 bit) and output gated_cycles_o (32 bits), counting cycles spent in GATED, saturating at 0xFFFFFFFF; stats_clr_i SHALL clear it and take precedence over increment; reset value SHALL be 0.
REQ-026 Macro undefined: the stats ports and counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-027 The state enum type and the stats width constant SHALL live in shared package clk_gate_pkg.
REQ-028 SHALL instantiate exactly one sub-module, prim_clock_gating, with clk_i→clk_i, clk_en_o→en_i, test_en_i→test_en_i and clk_o→clk_o.

Verification
REQ-029 With IDLE_CYCLES=4 and idle_i=1 from cycle 0: clk_en_o SHALL be 0 from cycle 5 and gated_o SHALL be 1.
REQ-030 With idle_i=1 for 3 cycles then 0 (IDLE_CYCLES=4): SHALL return to RUN and clk_en_o SHALL never drop.
REQ-031 With the FSM in GATED and a 1-cycle wake_i pulse (WAKE_CYCLES=2): clk_en_o=1 next cycle, ready_o=1 three cycles after the pulse.
REQ-032 With force_on_i=1 and idle_i=1 for 100 cycles: gated_o SHALL stay 0; with test_en_i=1 during GATED, clk_o SHALL toggle.
REQ-033 With rst_i pulsed in GATED: clk_en_o SHALL be 1 during reset, the state SHALL be RUN after reset, and clk_o SHALL show no glitch.
REQ-034 With STATS_EN defined and 10 cycles in GATED: gated_cycles_o SHALL read 10; after stats_clr_i it SHALL read 0; when preloaded to 0xFFFFFFFF it SHALL hold.

Source files
------------

// File: rtl/clk_gate_pkg.sv
// Shared types and constants for the clock-gate controller.
// Shared by clk_gate_ctrl and its optional statistics counter.
package clk_gate_pkg;

   typedef enum logic [1:0] {
      StRun,
      StIdleWait,
      StGated,
      StWake
   } cg_state_e;

   localparam int unsigned StatsW = 32;

endpackage

// File: rtl/prim_clock_gating.sv
// Latch-based clock gate cell: enable is captured while clk_i is low, so the
// gated clock can only start or stop on whole high phases.
module prim_clock_gating (
   input  logic clk_i,
   input  logic en_i,
   input  logic test_en_i,
   output logic clk_o
);

   logic en_latch;

   always_latch begin
      if (!clk_i) begin
         en_latch = en_i | test_en_i;
      end
   end

   assign clk_o = clk_i & en_latch;

endmodule

// File: rtl/clk_gate_ctrl.sv
// Idle-driven clock gating controller: RUN -> IDLE_WAIT -> GATED -> WAKE -> RUN.
// Define CLK_GATE_CTRL_STATS_EN to add a saturating gated-cycle counter.
module clk_gate_ctrl
   import clk_gate_pkg::*;
#(
   parameter int unsigned IDLE_CYCLES = 16,
   parameter int unsigned WAKE_CYCLES = 2,
   parameter int unsigned CNT_W       = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              idle_i,
   input  logic              wake_i,
   input  logic              force_on_i,
   input  logic              test_en_i,
`ifdef CLK_GATE_CTRL_STATS_EN
   input  logic              stats_clr_i,
   output logic [StatsW-1:0] gated_cycles_o,
`endif
   output logic              clk_o,
   output logic              clk_en_o,
   output logic              ready_o,
   output logic              gated_o
);

   localparam logic [CNT_W-1:0] IdleLast = CNT_W'(IDLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] WakeLast = CNT_W'(WAKE_CYCLES - 1);

   cg_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StRun: begin
            if (idle_i && !wake_i && !force_on_i) begin
               state_d = StIdleWait;
               cnt_d   = '0;
            end
         end
         StIdleWait: begin
            // Abort wins over the gate decision taken in the same cycle.
            if (!idle_i || wake_i || force_on_i) begin
               state_d = StRun;
            end else if (cnt_q == IdleLast) begin
               state_d = StGated;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StGated: begin
            if (wake_i || force_on_i || !idle_i) begin
               state_d = StWake;
               cnt_d   = '0;
            end
         end
         StWake: begin
            if (cnt_q == WakeLast) begin
               state_d = StRun;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = StRun;
      endcase
   end

   // Outputs are decoded from the next state so they line up with state_q.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= StRun;
         cnt_q    <= '0;
         clk_en_o <= 1'b1;
         ready_o  <= 1'b1;
         gated_o  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         clk_en_o <= (state_d != StGated);
         ready_o  <= (state_d == StRun) || (state_d == StIdleWait);
         gated_o  <= (state_d == StGated);
      end
   end

`ifdef CLK_GATE_CTRL_STATS_EN
   logic [StatsW-1:0] gated_cycles_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         gated_cycles_q <= '0;
      end else if (stats_clr_i) begin
         gated_cycles_q <= '0;
      end else if ((state_q == StGated) && (gated_cycles_q != '1)) begin
         gated_cycles_q <= gated_cycles_q + StatsW'(1);
      end
   end

   assign gated_cycles_o = gated_cycles_q;
`endif

   prim_clock_gating u_prim_clock_gating (
      .clk_i     (clk_i),
      .en_i      (clk_en_o),
      .test_en_i (test_en_i),
      .clk_o     (clk_o)
   );

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Scoreboard bench for clk_gate_ctrl with IDLE_CYCLES=4, WAKE_CYCLES=2.
// Stats checks are compiled in when CLK_GATE_CTRL_STATS_EN is defined.
module tb_clk_gate_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        idle_i = 1'b0;
   logic        wake_i = 1'b0;
   logic        force_on_i = 1'b0;
   logic        test_en_i = 1'b0;
   logic        stats_clr_i = 1'b0;
   logic [31:0] gated_cycles_o;
   logic        clk_o, clk_en_o, ready_o, gated_o;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   typedef struct {
      logic        en;
      logic        rdy;
      logic        gated;
      logic        clk_g;
      logic [31:0] stats;
   } exp_t;

   exp_t        sb_q[$];
   logic        prev_en = 1'b1;
   logic        prev_gated = 1'b0;
   logic [31:0] exp_stats = '0;
   int unsigned step_idx = 0;

   always #5 clk_i = ~clk_i;

   clk_gate_ctrl #(
      .IDLE_CYCLES (4),
      .WAKE_CYCLES (2),
      .CNT_W       (8)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .idle_i         (idle_i),
      .wake_i         (wake_i),
      .force_on_i     (force_on_i),
      .test_en_i      (test_en_i),
`ifdef CLK_GATE_CTRL_STATS_EN
      .stats_clr_i    (stats_clr_i),
      .gated_cycles_o (gated_cycles_o),
`endif
      .clk_o          (clk_o),
      .clk_en_o       (clk_en_o),
      .ready_o        (ready_o),
      .gated_o        (gated_o)
   );

`ifndef CLK_GATE_CTRL_STATS_EN
   assign gated_cycles_o = '0;
`endif

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive one cycle of inputs and the outputs expected after the next edge.
   task automatic drive(input logic idle, input logic wake, input logic frc, input logic clr,
                        input logic e_en, input logic e_rdy, input logic e_gated,
                        input string tag);
      exp_t e;
      string t;
      @(negedge clk_i);
      idle_i      = idle;
      wake_i      = wake;
      force_on_i  = frc;
      stats_clr_i = clr;
      e.en    = e_en;
      e.rdy   = e_rdy;
      e.gated = e_gated;
      // The gate latch samples the enable present before this edge.
      e.clk_g = prev_en | test_en_i;
      if (clr) e.stats = '0;
      else if (prev_gated && exp_stats != 32'hFFFF_FFFF) e.stats = exp_stats + 1;
      else e.stats = exp_stats;
      sb_q.push_back(e);
      prev_en    = e_en;
      prev_gated = e_gated;
      exp_stats  = e.stats;
      @(posedge clk_i);
      #1;
      e = sb_q.pop_front();
      t = $sformatf("%s#%0d", tag, step_idx);
      step_idx++;
      check_val({t, ".clk_en"}, {31'b0, clk_en_o}, {31'b0, e.en});
      check_val({t, ".ready"}, {31'b0, ready_o}, {31'b0, e.rdy});
      check_val({t, ".gated"}, {31'b0, gated_o}, {31'b0, e.gated});
      check_val({t, ".clk_o"}, {31'b0, clk_o}, {31'b0, e.clk_g});
`ifdef CLK_GATE_CTRL_STATS_EN
      check_val({t, ".stats"}, gated_cycles_o, e.stats);
`endif
   endtask

   initial begin
      #1 rst_i = 1'b1;
      #6;
      check_val("rst.clk_en", {31'b0, clk_en_o}, 32'd1);
      check_val("rst.ready", {31'b0, ready_o}, 32'd1);
      check_val("rst.gated", {31'b0, gated_o}, 32'd0);
`ifdef CLK_GATE_CTRL_STATS_EN
      check_val("rst.stats", gated_cycles_o, 32'd0);
`endif
      @(negedge clk_i);
      rst_i = 1'b0;

      // Idle from the first edge: enable drops after the fifth edge.
      for (int i = 0; i < 15; i++) begin
         if (i < 4) drive(1, 0, 0, 0, 1, 1, 0, "idle_gate");
         else drive(1, 0, 0, 0, 0, 0, 1, "idle_gate");
      end
`ifdef CLK_GATE_CTRL_STATS_EN
      check_val("stats10", gated_cycles_o, 32'd10);
`endif
      drive(1, 0, 0, 1, 0, 0, 1, "stats_clr");
`ifdef CLK_GATE_CTRL_STATS_EN
      check_val("stats_clr0", gated_cycles_o, 32'd0);
`endif

      // Test enable forces the gated clock through while still GATED.
      test_en_i = 1'b1;
      drive(1, 0, 0, 0, 0, 0, 1, "test_en");
      drive(1, 0, 0, 0, 0, 0, 1, "test_en");
      @(negedge clk_i);
      test_en_i = 1'b0;
      prev_en   = 1'b0;

      // One-cycle wake pulse: enable next edge, ready two edges later.
      drive(1, 1, 0, 0, 1, 0, 0, "wake");
      drive(1, 0, 0, 0, 1, 0, 0, "wake");
      drive(0, 0, 0, 0, 1, 1, 0, "wake");
      drive(0, 0, 0, 0, 1, 1, 0, "run");

      // Short idle burst returns to RUN without ever dropping the enable.
      for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 1, 1, 0, "short_idle");
      drive(0, 0, 0, 0, 1, 1, 0, "short_idle");
      drive(0, 0, 0, 0, 1, 1, 0, "short_idle");

      // Wake arriving on the gate-decision cycle aborts the gate.
      for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 1, 1, 0, "abort");
      drive(1, 1, 0, 0, 1, 1, 0, "abort");
      drive(0, 0, 0, 0, 1, 1, 0, "abort");

      // force_on holds the controller out of GATED indefinitely.
      for (int i = 0; i < 100; i++) drive(1, 0, 1, 0, 1, 1, 0, "force_on");
      drive(0, 0, 0, 0, 1, 1, 0, "force_on");

      // Gate again, then wake via force_on.
      for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 1, 1, 0, "gate2");
      drive(1, 0, 0, 0, 0, 0, 1, "gate2");
      drive(1, 0, 1, 0, 1, 0, 0, "force_wake");
      drive(1, 0, 1, 0, 1, 0, 0, "force_wake");
      drive(1, 0, 1, 0, 1, 1, 0, "force_wake");
      drive(1, 0, 1, 0, 1, 1, 0, "force_wake");

      // Gate again, wake via idle dropping; idle is ignored during WAKE.
      for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 1, 1, 0, "gate3");
      drive(1, 0, 0, 0, 0, 0, 1, "gate3");
      drive(0, 0, 0, 0, 1, 0, 0, "idle_wake");
      drive(1, 0, 0, 0, 1, 0, 0, "idle_wake");
      drive(0, 0, 0, 0, 1, 1, 0, "idle_wake");

      // Reset in GATED during the high phase: enable returns at once, no runt.
      for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 1, 1, 0, "gate4");
      drive(1, 0, 0, 0, 0, 0, 1, "gate4");
      drive(1, 0, 0, 0, 0, 0, 1, "gate4");
      #1;
      rst_i  = 1'b1;
      idle_i = 1'b0;
      #1;
      check_val("rst_gated.clk_en", {31'b0, clk_en_o}, 32'd1);
      check_val("rst_gated.ready", {31'b0, ready_o}, 32'd1);
      check_val("rst_gated.gated", {31'b0, gated_o}, 32'd0);
      check_val("rst_gated.no_runt", {31'b0, clk_o}, 32'd0);
`ifdef CLK_GATE_CTRL_STATS_EN
      check_val("rst_gated.stats", gated_cycles_o, 32'd0);
`endif
      @(negedge clk_i);
      #1;
      check_val("rst_gated.clk_low", {31'b0, clk_o}, 32'd0);
      rst_i      = 1'b0;
      prev_en    = 1'b1;
      prev_gated = 1'b0;
      exp_stats  = '0;
      drive(0, 0, 0, 0, 1, 1, 0, "post_rst");
      drive(0, 0, 0, 0, 1, 1, 0, "post_rst");

      if (sb_q.size() != 0) begin
         check_val("sb_empty", sb_q.size(), 32'd0);
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
